sap_control_sequencer: RTL and testbench
========================================

Name: sap_control_sequencer

Overview:
- Instruction register, flags register and T-state microcode sequencer for the SAP-U datapath.
- Drives every active-low load and bus-enable strobe of register A, register B, ALU, RAM/MAR and the program counter, so that only one source drives the bus per step.
- Captures each instruction from the bus and places its 4-bit operand back on the bus.
- Latches the ALU carry and zero flags used by conditional jumps.

Parameters:
- SHORT_CYCLE, 1: 1 = return to T0 right after an instruction's last active step; 0 = always run T0..T4.
- HALT_ON_UNDEF, 0: 1 = opcodes 9..D halt; 0 = they execute as NOP.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  step enable; 0 freezes state.
- bus_in  in  8  data bus, sampled for instruction load.
- alu_carry  in  1  ALU carry-out.
- alu_zero  in  1  ALU result == 0.
- ir_bus_out  out  8  {4'h0, ir[3:0]}.
- ir_bus_enable_n  out  1  operand onto bus.
- opcode  out  4  ir[7:4].
- step  out  3  current T-state, 0..4.
- halted  out  1  HLT executed.
- flag_carry, flag_zero  out  1 each  latched flags.
- ram_load_mar_reg_n, ram_bus_enable_n, ram_write_enable_n  out  1 each.
- reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n  out  1 each.
- alu_enable_n, alu_subtract  out  1 each.
- program_counter_enable, program_counter_bus_enable_n, jump_n  out  1 each.
- out_load_n  out  1  output-display register load.

Behaviour:
- Reset (reset=0, asynchronous): step=0, ir=8'h00, flags=0, halted=0.
  - All _n strobes =1; program_counter_enable=0; alu_subtract=0.
- Timing:
  - State (step, ir, flags, halted) updates on the rising edge of clk.
  - Strobes are combinational from (step, opcode, flags, run, halted, reset).
  - The datapath acts on the next rising edge: one-cycle latency per step.
- Strobe gating: when run=0, or halted=1, or reset=0, all strobes are deasserted and state holds.
- Fetch, all opcodes:
  - T0: program_counter_bus_enable_n=0, ram_load_mar_reg_n=0.
  - T1: ram_bus_enable_n=0, program_counter_enable=1, internal ir_load. ir<=bus_in at the edge ending T1.
- Execute steps (unlisted steps are empty; operand = ir_bus_enable_n=0):
  - 0 NOP: none.
  - 1 LDA: T2 operand+MAR load; T3 RAM out+reg A load.
  - 2 ADD: T2 operand+MAR load; T3 RAM out+reg B load; T4 alu_enable_n=0, reg_a_load_n=0, flag load.
  - 3 SUB: same as ADD; alu_subtract=1 during T3 and T4.
  - 4 STA: T2 operand+MAR load; T3 reg_a_bus_enable_n=0, ram_write_enable_n=0.
  - 5 LDI: T2 operand+reg A load.
  - 6 JMP: T2 operand+jump_n=0.
  - 7 JC: T2 operand; jump_n=0 only if flag_carry=1.
  - 8 JZ: T2 operand; jump_n=0 only if flag_zero=1.
  - E OUT: T2 reg_a_bus_enable_n=0, out_load_n=0.
  - F HLT: halted<=1 at the edge ending T2.
  - 9..D: NOP, or HLT if HALT_ON_UNDEF=1.
- Flag load: at the edge ending ADD/SUB T4, flag_carry<=alu_carry and flag_zero<=alu_zero. No other step changes the flags.
- Step advance:
  - SHORT_CYCLE=1: the last step is T2 for NOP/LDI/JMP/JC/JZ/OUT/undefined, T3 for LDA/STA, T4 for ADD/SUB. After the last step, step<=0.
  - SHORT_CYCLE=0: always 0..4, then 0.
- Halt: step freezes at 2 and halted stays 1 until reset. run has no effect while halted.
- Mutual exclusion: at most one *_bus_enable_n is low in any step. The bench asserts this every cycle.
- Reset mid-instruction: immediate return to reset values; the next fetch starts at T0.

Test Plan:
- Reset, run=1, bus_in=8'h1A at T1:
  - T0 shows PC-out+MAR-load; T1 shows RAM-out+PC-enable.
  - opcode=1 after T1; T2 ir_bus_out=8'h0A with MAR load; T3 RAM-out+A-load; step returns to 0 after T3.
- ADD 8'h2F, alu_carry=1, alu_zero=0:
  - T4 has alu_enable_n=0, reg_a_load_n=0, alu_subtract=0.
  - After T4: flag_carry=1, flag_zero=0.
  - SUB 8'h3F repeats this with alu_subtract=1 in T3/T4.
- JC 8'h75 with flag_carry=1 -> T2 jump_n=0, ir_bus_out=8'h05. Repeat with flag_carry=0 -> jump_n stays 1, step->0.
- HLT 8'hF0:
  - halted=1 after T2; step stays 2; all strobes inactive for 10 cycles with run=1.
  - reset=0 clears halted.
- run=0 during LDA T3 for 4 cycles -> step holds 3, all strobes inactive; run=1 resumes T3 strobes.
- Async reset asserted mid-ADD T3 (between edges) -> outputs inactive immediately; after release, step=0 and flags=0.
- SHORT_CYCLE=0, LDI 8'h57 -> T2 operand+A-load; steps 3 and 4 have no strobes; wraps to 0 after T4.

Source files
------------

// File: rtl/sap_control_sequencer_if.sv
// Datapath-side signal bundle for the SAP-U control sequencer: step enable,
// instruction bus, ALU status inputs, decoded state and all control strobes.
interface sap_control_sequencer_if;
    // Inputs to the sequencer
    logic       run;
    logic [7:0] bus_in;
    logic       alu_carry;
    logic       alu_zero;

    // Instruction register / state visibility
    logic [7:0] ir_bus_out;
    logic       ir_bus_enable_n;
    logic [3:0] opcode;
    logic [2:0] step;
    logic       halted;
    logic       flag_carry;
    logic       flag_zero;

    // RAM / MAR strobes
    logic       ram_load_mar_reg_n;
    logic       ram_bus_enable_n;
    logic       ram_write_enable_n;

    // Register A / B strobes
    logic       reg_a_load_n;
    logic       reg_a_bus_enable_n;
    logic       reg_b_load_n;

    // ALU strobes
    logic       alu_enable_n;
    logic       alu_subtract;

    // Program counter strobes
    logic       program_counter_enable;
    logic       program_counter_bus_enable_n;
    logic       jump_n;

    // Output display
    logic       out_load_n;

    // Sequencer side
    modport master (
        input  run, bus_in, alu_carry, alu_zero,
        output ir_bus_out, ir_bus_enable_n, opcode, step, halted,
        output flag_carry, flag_zero,
        output ram_load_mar_reg_n, ram_bus_enable_n, ram_write_enable_n,
        output reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n,
        output alu_enable_n, alu_subtract,
        output program_counter_enable, program_counter_bus_enable_n, jump_n,
        output out_load_n
    );

    // Datapath side
    modport slave (
        output run, bus_in, alu_carry, alu_zero,
        input  ir_bus_out, ir_bus_enable_n, opcode, step, halted,
        input  flag_carry, flag_zero,
        input  ram_load_mar_reg_n, ram_bus_enable_n, ram_write_enable_n,
        input  reg_a_load_n, reg_a_bus_enable_n, reg_b_load_n,
        input  alu_enable_n, alu_subtract,
        input  program_counter_enable, program_counter_bus_enable_n, jump_n,
        input  out_load_n
    );
endinterface

// File: rtl/sap_control_sequencer.sv
// SAP-U control sequencer: instruction register, carry/zero flags and the
// T-state microcode that drives every datapath strobe. Strobes are decoded
// combinationally from the current step/opcode; the datapath acts on them at
// the following rising edge.
module sap_control_sequencer #(
    parameter int unsigned SHORT_CYCLE   = 1,
    parameter int unsigned HALT_ON_UNDEF = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    sap_control_sequencer_if.master       bus
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    // State registers
    step_e      step_q, step_d;
    logic [7:0] ir_q, ir_d;
    logic       flag_carry_q, flag_carry_d;
    logic       flag_zero_q, flag_zero_d;
    logic       halted_q, halted_d;

    // Decoded strobes (internal, before driving the interface)
    logic       ir_bus_enable_n;
    logic       ram_load_mar_reg_n;
    logic       ram_bus_enable_n;
    logic       ram_write_enable_n;
    logic       reg_a_load_n;
    logic       reg_a_bus_enable_n;
    logic       reg_b_load_n;
    logic       alu_enable_n;
    logic       alu_subtract;
    logic       program_counter_enable;
    logic       program_counter_bus_enable_n;
    logic       jump_n;
    logic       out_load_n;

    // Decode helpers
    logic [3:0] op;
    logic       active;
    logic       op_undef;
    logic       op_halts;
    step_e      last_step;

    assign op       = ir_q[7:4];
    assign active   = bus.run && !halted_q && reset;
    assign op_undef = (op >= 4'h9) && (op <= 4'hD);
    assign op_halts = (op == OP_HLT) || (op_undef && (HALT_ON_UNDEF != 0));

    // Last active step of the current instruction when SHORT_CYCLE is set
    always_comb begin
        last_step = T2;
        case (op)
            OP_LDA, OP_STA: last_step = T3;
            OP_ADD, OP_SUB: last_step = T4;
            default:        last_step = T2;
        endcase
    end

    // Next-state and strobe decode
    always_comb begin
        step_d       = step_q;
        ir_d         = ir_q;
        flag_carry_d = flag_carry_q;
        flag_zero_d  = flag_zero_q;
        halted_d     = halted_q;

        ir_bus_enable_n              = 1'b1;
        ram_load_mar_reg_n           = 1'b1;
        ram_bus_enable_n             = 1'b1;
        ram_write_enable_n           = 1'b1;
        reg_a_load_n                 = 1'b1;
        reg_a_bus_enable_n           = 1'b1;
        reg_b_load_n                 = 1'b1;
        alu_enable_n                 = 1'b1;
        alu_subtract                 = 1'b0;
        program_counter_enable       = 1'b0;
        program_counter_bus_enable_n = 1'b1;
        jump_n                       = 1'b1;
        out_load_n                   = 1'b1;

        if (active) begin
            case (step_q)
                T0: begin
                    program_counter_bus_enable_n = 1'b0;
                    ram_load_mar_reg_n           = 1'b0;
                end
                T1: begin
                    ram_bus_enable_n       = 1'b0;
                    program_counter_enable = 1'b1;
                    ir_d                   = bus.bus_in;
                end
                T2: begin
                    case (op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_bus_enable_n    = 1'b0;
                            ram_load_mar_reg_n = 1'b0;
                        end
                        OP_LDI: begin
                            ir_bus_enable_n = 1'b0;
                            reg_a_load_n    = 1'b0;
                        end
                        OP_JMP: begin
                            ir_bus_enable_n = 1'b0;
                            jump_n          = 1'b0;
                        end
                        OP_JC: begin
                            ir_bus_enable_n = 1'b0;
                            jump_n          = !flag_carry_q;
                        end
                        OP_JZ: begin
                            ir_bus_enable_n = 1'b0;
                            jump_n          = !flag_zero_q;
                        end
                        OP_OUT: begin
                            reg_a_bus_enable_n = 1'b0;
                            out_load_n         = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (op)
                        OP_LDA: begin
                            ram_bus_enable_n = 1'b0;
                            reg_a_load_n     = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_bus_enable_n = 1'b0;
                            reg_b_load_n     = 1'b0;
                            alu_subtract     = (op == OP_SUB);
                        end
                        OP_STA: begin
                            reg_a_bus_enable_n = 1'b0;
                            ram_write_enable_n = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if ((op == OP_ADD) || (op == OP_SUB)) begin
                        alu_enable_n = 1'b0;
                        reg_a_load_n = 1'b0;
                        alu_subtract = (op == OP_SUB);
                        flag_carry_d = bus.alu_carry;
                        flag_zero_d  = bus.alu_zero;
                    end
                end
                default: ;
            endcase

            // Halting freezes the step at T2; otherwise advance or wrap
            if (op_halts && (step_q == T2)) begin
                halted_d = 1'b1;
                step_d   = step_q;
            end else if ((step_q == T4) ||
                         ((SHORT_CYCLE != 0) && (step_q == last_step))) begin
                step_d = T0;
            end else begin
                step_d = step_e'(step_q + 3'd1);
            end
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_q       <= T0;
            ir_q         <= '0;
            flag_carry_q <= 1'b0;
            flag_zero_q  <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            step_q       <= step_d;
            ir_q         <= ir_d;
            flag_carry_q <= flag_carry_d;
            flag_zero_q  <= flag_zero_d;
            halted_q     <= halted_d;
        end
    end

    assign bus.ir_bus_out                   = {4'h0, ir_q[3:0]};
    assign bus.ir_bus_enable_n              = ir_bus_enable_n;
    assign bus.opcode                       = op;
    assign bus.step                         = step_q;
    assign bus.halted                       = halted_q;
    assign bus.flag_carry                   = flag_carry_q;
    assign bus.flag_zero                    = flag_zero_q;
    assign bus.ram_load_mar_reg_n           = ram_load_mar_reg_n;
    assign bus.ram_bus_enable_n             = ram_bus_enable_n;
    assign bus.ram_write_enable_n           = ram_write_enable_n;
    assign bus.reg_a_load_n                 = reg_a_load_n;
    assign bus.reg_a_bus_enable_n           = reg_a_bus_enable_n;
    assign bus.reg_b_load_n                 = reg_b_load_n;
    assign bus.alu_enable_n                 = alu_enable_n;
    assign bus.alu_subtract                 = alu_subtract;
    assign bus.program_counter_enable       = program_counter_enable;
    assign bus.program_counter_bus_enable_n = program_counter_bus_enable_n;
    assign bus.jump_n                       = jump_n;
    assign bus.out_load_n                   = out_load_n;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for sap_control_sequencer: one short-cycle instance for the
// instruction set, halt, run-freeze and async reset; one full-cycle instance
// for the fixed T0..T4 sequence.
module tb_sap_control_sequencer;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    int unsigned errors = 0;
    int unsigned checks = 0;

    sap_control_sequencer_if sif ();
    sap_control_sequencer_if sif2 ();

    sap_control_sequencer #(.SHORT_CYCLE(1), .HALT_ON_UNDEF(0)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    sap_control_sequencer #(.SHORT_CYCLE(0), .HALT_ON_UNDEF(0)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (sif2)
    );

    always #5 clk = ~clk;

    // Strobe vector bit order (idle level in brackets):
    // 12 ir_be_n[1] 11 mar_n[1] 10 ram_be_n[1] 9 ram_we_n[1] 8 a_load_n[1]
    // 7 a_be_n[1] 6 b_load_n[1] 5 alu_en_n[1] 4 alu_sub[0] 3 pc_en[0]
    // 2 pc_be_n[1] 1 jump_n[1] 0 out_load_n[1]
    localparam logic [12:0] IDLE   = 13'b1111111100111;
    localparam logic [12:0] M_IR   = 13'h1 << 12;
    localparam logic [12:0] M_MAR  = 13'h1 << 11;
    localparam logic [12:0] M_RAMO = 13'h1 << 10;
    localparam logic [12:0] M_RAMW = 13'h1 << 9;
    localparam logic [12:0] M_AL   = 13'h1 << 8;
    localparam logic [12:0] M_AO   = 13'h1 << 7;
    localparam logic [12:0] M_BL   = 13'h1 << 6;
    localparam logic [12:0] M_ALU  = 13'h1 << 5;
    localparam logic [12:0] M_SUB  = 13'h1 << 4;
    localparam logic [12:0] M_PCE  = 13'h1 << 3;
    localparam logic [12:0] M_PCO  = 13'h1 << 2;
    localparam logic [12:0] M_J    = 13'h1 << 1;
    localparam logic [12:0] M_OUT  = 13'h1;

    logic [12:0] strb1, strb2;
    assign strb1 = {sif.ir_bus_enable_n, sif.ram_load_mar_reg_n, sif.ram_bus_enable_n,
                    sif.ram_write_enable_n, sif.reg_a_load_n, sif.reg_a_bus_enable_n,
                    sif.reg_b_load_n, sif.alu_enable_n, sif.alu_subtract,
                    sif.program_counter_enable, sif.program_counter_bus_enable_n,
                    sif.jump_n, sif.out_load_n};
    assign strb2 = {sif2.ir_bus_enable_n, sif2.ram_load_mar_reg_n, sif2.ram_bus_enable_n,
                    sif2.ram_write_enable_n, sif2.reg_a_load_n, sif2.reg_a_bus_enable_n,
                    sif2.reg_b_load_n, sif2.alu_enable_n, sif2.alu_subtract,
                    sif2.program_counter_enable, sif2.program_counter_bus_enable_n,
                    sif2.jump_n, sif2.out_load_n};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned bus_drivers(input logic a, input logic b,
                                                input logic c, input logic d);
        return int'(!a) + int'(!b) + int'(!c) + int'(!d);
    endfunction

    // At most one bus source per step, every cycle, both instances
    always @(negedge clk) begin
        check("bus_excl1", 32'(bus_drivers(sif.ir_bus_enable_n, sif.ram_bus_enable_n,
                                           sif.reg_a_bus_enable_n,
                                           sif.program_counter_bus_enable_n) <= 1), 1);
        check("bus_excl2", 32'(bus_drivers(sif2.ir_bus_enable_n, sif2.ram_bus_enable_n,
                                           sif2.reg_a_bus_enable_n,
                                           sif2.program_counter_bus_enable_n) <= 1), 1);
    end

    // Check step and strobes of one instance at the current time
    task automatic chk(input string tag, input int unsigned st, input logic [12:0] m,
                       input bit d2 = 1'b0);
        if (d2) begin
            check({tag, "_step"}, 32'(sif2.step), st);
            check({tag, "_strb"}, 32'(strb2), 32'(IDLE ^ m));
        end else begin
            check({tag, "_step"}, 32'(sif.step), st);
            check({tag, "_strb"}, 32'(strb1), 32'(IDLE ^ m));
        end
    endtask

    task automatic adv();
        @(negedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input int unsigned st, input logic [12:0] m,
                       input bit d2 = 1'b0);
        chk(tag, st, m, d2);
        adv();
    endtask

    initial begin
        sif.run = 1'b1;  sif.bus_in = 8'h00;  sif.alu_carry = 1'b0;  sif.alu_zero = 1'b0;
        sif2.run = 1'b0; sif2.bus_in = 8'h00; sif2.alu_carry = 1'b0; sif2.alu_zero = 1'b0;
        reset = 1'b0;
        #3;
        chk("rst", 0, '0);
        check("rst_halted", 32'(sif.halted), 0);
        check("rst_flags", 32'({sif.flag_carry, sif.flag_zero}), 0);
        check("rst_irout", 32'(sif.ir_bus_out), 0);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;

        // LDA 1A
        sif.bus_in = 8'h1A;
        cyc("lda_t0", 0, M_PCO | M_MAR);
        cyc("lda_t1", 1, M_RAMO | M_PCE);
        check("lda_opcode", 32'(sif.opcode), 1);
        check("lda_irout", 32'(sif.ir_bus_out), 32'h0A);
        cyc("lda_t2", 2, M_IR | M_MAR);
        cyc("lda_t3", 3, M_RAMO | M_AL);

        // ADD 2F, carry=1 zero=0
        sif.bus_in = 8'h2F; sif.alu_carry = 1'b1; sif.alu_zero = 1'b0;
        cyc("add_t0", 0, M_PCO | M_MAR);
        cyc("add_t1", 1, M_RAMO | M_PCE);
        cyc("add_t2", 2, M_IR | M_MAR);
        cyc("add_t3", 3, M_RAMO | M_BL);
        cyc("add_t4", 4, M_ALU | M_AL);
        check("add_flags", 32'({sif.flag_carry, sif.flag_zero}), 32'b10);

        // JC 75 taken
        sif.bus_in = 8'h75; sif.alu_carry = 1'b0; sif.alu_zero = 1'b0;
        cyc("jct_t0", 0, M_PCO | M_MAR);
        cyc("jct_t1", 1, M_RAMO | M_PCE);
        check("jct_irout", 32'(sif.ir_bus_out), 32'h05);
        cyc("jct_t2", 2, M_IR | M_J);

        // SUB 3F, carry=0 zero=1
        sif.bus_in = 8'h3F; sif.alu_carry = 1'b0; sif.alu_zero = 1'b1;
        cyc("sub_t0", 0, M_PCO | M_MAR);
        cyc("sub_t1", 1, M_RAMO | M_PCE);
        cyc("sub_t2", 2, M_IR | M_MAR);
        cyc("sub_t3", 3, M_RAMO | M_BL | M_SUB);
        cyc("sub_t4", 4, M_ALU | M_AL | M_SUB);
        check("sub_flags", 32'({sif.flag_carry, sif.flag_zero}), 32'b01);

        // JC 75 not taken, then JZ 83 taken
        sif.bus_in = 8'h75; sif.alu_carry = 1'b1; sif.alu_zero = 1'b0;
        cyc("jcn_t0", 0, M_PCO | M_MAR);
        cyc("jcn_t1", 1, M_RAMO | M_PCE);
        cyc("jcn_t2", 2, M_IR);
        sif.bus_in = 8'h83;
        cyc("jz_t0", 0, M_PCO | M_MAR);
        cyc("jz_t1", 1, M_RAMO | M_PCE);
        check("jz_irout", 32'(sif.ir_bus_out), 32'h03);
        cyc("jz_t2", 2, M_IR | M_J);
        check("jz_flags_kept", 32'({sif.flag_carry, sif.flag_zero}), 32'b01);

        // STA 4C, OUT E0, undefined 9A (NOP)
        sif.bus_in = 8'h4C;
        cyc("sta_t0", 0, M_PCO | M_MAR);
        cyc("sta_t1", 1, M_RAMO | M_PCE);
        cyc("sta_t2", 2, M_IR | M_MAR);
        cyc("sta_t3", 3, M_AO | M_RAMW);
        sif.bus_in = 8'hE0;
        cyc("out_t0", 0, M_PCO | M_MAR);
        cyc("out_t1", 1, M_RAMO | M_PCE);
        cyc("out_t2", 2, M_AO | M_OUT);
        sif.bus_in = 8'h9A;
        cyc("und_t0", 0, M_PCO | M_MAR);
        cyc("und_t1", 1, M_RAMO | M_PCE);
        cyc("und_t2", 2, '0);
        check("und_halted", 32'(sif.halted), 0);

        // LDA with run=0 for 4 cycles in T3
        sif.bus_in = 8'h1A;
        cyc("frz_t0", 0, M_PCO | M_MAR);
        cyc("frz_t1", 1, M_RAMO | M_PCE);
        cyc("frz_t2", 2, M_IR | M_MAR);
        chk("frz_t3", 3, M_RAMO | M_AL);
        sif.run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            adv();
            chk("frz_hold", 3, '0);
        end
        sif.run = 1'b1;
        #1;
        chk("frz_resume", 3, M_RAMO | M_AL);
        adv();

        // ADD interrupted by async reset in T3
        sif.bus_in = 8'h2F; sif.alu_carry = 1'b1; sif.alu_zero = 1'b0;
        cyc("arst_t0", 0, M_PCO | M_MAR);
        cyc("arst_t1", 1, M_RAMO | M_PCE);
        cyc("arst_t2", 2, M_IR | M_MAR);
        chk("arst_t3", 3, M_RAMO | M_BL);
        #1 reset = 1'b0;
        #1;
        chk("arst_mid", 0, '0);
        check("arst_flags", 32'({sif.flag_carry, sif.flag_zero}), 0);
        adv();
        reset = 1'b1;
        #1;

        // HLT F0
        sif.bus_in = 8'hF0;
        cyc("hlt_t0", 0, M_PCO | M_MAR);
        cyc("hlt_t1", 1, M_RAMO | M_PCE);
        cyc("hlt_t2", 2, '0);
        for (int i = 0; i < 10; i++) begin
            chk("hlt_hold", 2, '0);
            check("hlt_halted", 32'(sif.halted), 1);
            adv();
        end
        reset = 1'b0;
        #1;
        check("hlt_rst_halted", 32'(sif.halted), 0);
        check("hlt_rst_step", 32'(sif.step), 0);

        // Full-cycle instance: LDI 57 runs T0..T4 then wraps
        sif.run = 1'b0;
        sif2.run = 1'b1; sif2.bus_in = 8'h57;
        adv();
        reset = 1'b1;
        #1;
        cyc("ldi_t0", 0, M_PCO | M_MAR, 1'b1);
        cyc("ldi_t1", 1, M_RAMO | M_PCE, 1'b1);
        check("ldi_irout", 32'(sif2.ir_bus_out), 32'h07);
        cyc("ldi_t2", 2, M_IR | M_AL, 1'b1);
        cyc("ldi_t3", 3, '0, 1'b1);
        cyc("ldi_t4", 4, '0, 1'b1);
        chk("ldi_wrap", 0, M_PCO | M_MAR, 1'b1);
        check("idle_dut1_step", 32'(sif.step), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
